// File: rtl/mult8_pow_seq.sv
// mult8_pow_seq: computes a*b^n by driving one external registered mult8 n times.
// Ports:
//   i_clk, i_arst_n                     clock, async active-low reset
//   i_valid/o_ready, i_a, i_b, i_n      job request handshake and operands
//   o_valid/i_ready, o_result           result handshake and a*b^n
//   o_mult_a, o_mult_b                  operands to the external mult8
//   i_mult_product                      mult8 product, 1-cycle registered
// Build option: MULT8_POW_SEQ_EARLY_EXIT_EN ends a job once acc reaches zero.
module mult8_pow_seq #(
  parameter int N_W = 3
) (
  input  logic           i_clk,
  input  logic           i_arst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [7:0]     i_a,
  input  logic [7:0]     i_b,
  input  logic [N_W-1:0] i_n,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [7:0]     o_result,
  output logic [7:0]     o_mult_a,
  output logic [7:0]     o_mult_b,
  input  logic [7:0]     i_mult_product
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e         state_q;
  logic [7:0]     acc_q;
  logic [7:0]     b_q;
  logic [N_W-1:0] cnt_q;
  logic [N_W-1:0] cnt_d;
  logic           ready_q;
  logic           valid_q;
  logic           idle_fin;
  logic           wait_fin;

  assign cnt_d = cnt_q - N_W'(1);

`ifdef MULT8_POW_SEQ_EARLY_EXIT_EN
  // a zero accumulator stays zero, so remaining steps are skipped
  assign idle_fin = (i_n == '0) || (i_a == 8'd0);
  assign wait_fin = (cnt_q == N_W'(1)) || (i_mult_product == 8'd0);
`else
  assign idle_fin = (i_n == '0);
  assign wait_fin = (cnt_q == N_W'(1));
`endif

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= S_IDLE;
      acc_q   <= 8'd0;
      b_q     <= 8'd0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            acc_q   <= i_a;
            b_q     <= i_b;
            cnt_q   <= i_n;
            ready_q <= 1'b0;
            if (idle_fin) begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // operands already sit on o_mult_a/o_mult_b
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          acc_q <= i_mult_product;
          cnt_q <= cnt_d;
          if (wait_fin) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = acc_q;
  assign o_mult_a = acc_q;
  assign o_mult_b = b_q;

endmodule

// File: tb/tb_mult8_pow_seq.sv
// tb_mult8_pow_seq: directed scoreboard bench for mult8_pow_seq.
// Includes a behavioural 1-cycle registered mult8 beside the DUT.
module tb_mult8_pow_seq;

  localparam int N_W = 3;

`ifdef MULT8_POW_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic           i_clk = 1'b0;
  logic           i_arst_n = 1'b0;
  logic           i_valid = 1'b0;
  logic           o_ready;
  logic [7:0]     i_a = 8'd0;
  logic [7:0]     i_b = 8'd0;
  logic [N_W-1:0] i_n = '0;
  logic           o_valid;
  logic           i_ready = 1'b1;
  logic [7:0]     o_result;
  logic [7:0]     o_mult_a;
  logic [7:0]     o_mult_b;
  logic [7:0]     prod_q = 8'd0;
  logic [15:0]    full;

  mult8_pow_seq #(.N_W(N_W)) dut (
    .i_clk(i_clk),
    .i_arst_n(i_arst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_a(i_a),
    .i_b(i_b),
    .i_n(i_n),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_result(o_result),
    .o_mult_a(o_mult_a),
    .o_mult_b(o_mult_b),
    .i_mult_product(prod_q)
  );

  always #5 i_clk = ~i_clk;

  assign full = 16'(o_mult_a) * 16'(o_mult_b);
  always @(posedge i_clk) prod_q <= full[15:8];

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int res;
    int cyc;
    int hold;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   seen = 1'b0;
  int   hold = 0;

  // monitor: pops on the first cycle of each result and acts as consumer
  always @(negedge i_clk) begin
    if (!i_arst_n) begin
      seen = 1'b0;
      hold = 0;
      i_ready = 1'b1;
    end else if (o_valid) begin
      if (!seen) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          cur = q.pop_front();
          seen = 1'b1;
          hold = cur.hold;
          chk("result", int'(o_result), cur.res);
          chk("valid_cycle", cyc, cur.cyc);
        end
      end else begin
        chk("held_result", int'(o_result), cur.res);
        chk("held_ready", int'(o_ready), 0);
      end
      if (hold > 0) begin
        i_ready = 1'b0;
        hold--;
      end else begin
        i_ready = 1'b1;
      end
      if (i_ready) seen = 1'b0;
    end
  end

  task automatic idle_chk(input string nm);
    chk({nm, "_ready"}, int'(o_ready), 1);
    chk({nm, "_valid"}, int'(o_valid), 0);
    chk({nm, "_result"}, int'(o_result), 0);
    chk({nm, "_mult_a"}, int'(o_mult_a), 0);
    chk({nm, "_mult_b"}, int'(o_mult_b), 0);
  endtask

  // called at a negedge; returns at the negedge after the handshake
  task automatic job(input int a, input int b, input int n,
                     input int res, input int lat, input int hd,
                     input bit push);
    exp_t e;
    bit ok;
    ok = 1'b0;
    i_valid = 1'b1;
    i_a = 8'(a);
    i_b = 8'(b);
    i_n = N_W'(n);
    for (int k = 0; k < 100; k++) begin
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    if (!ok) chk("accept_timeout", 0, 1);
    e.res = res;
    e.cyc = cyc + lat;
    e.hold = hd;
    if (push) q.push_back(e);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_a = ~8'(a);
    i_b = ~8'(b);
    i_n = ~N_W'(n);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (q.size() == 0 && !o_valid && o_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  int ja[3] = '{200, 255, 77};
  int jb[3] = '{128, 255, 0};
  int jn[3] = '{2, 3, 0};
  int jr[3] = '{50, 252, 77};
  int jl[3] = '{5, 7, 1};

  initial begin
    exp_t e;
    int j;
    repeat (2) @(negedge i_clk);
    i_arst_n = 1'b1;
    @(negedge i_clk);
    idle_chk("reset");

    // abort a job while it sits in WAIT
    job(200, 128, 2, 0, 0, 0, 1'b0);
    @(negedge i_clk);
    chk("wait_mult_a", int'(o_mult_a), 200);
    chk("wait_mult_b", int'(o_mult_b), 128);
    #1 i_arst_n = 1'b0;
    #1 idle_chk("async_reset");
    @(negedge i_clk);
    i_arst_n = 1'b1;
    @(negedge i_clk);

    job(200, 128, 2, 50, 5, 4, 1'b1);
    drain();
    job(255, 255, 3, 252, 7, 0, 1'b1);
    drain();
    job(77, 9, 0, 77, 1, 0, 1'b1);
    drain();
    job(128, 255, 1, 127, 3, 0, 1'b1);
    drain();
    job(3, 64, 7, 0, EE ? 3 : 15, 0, 1'b1);
    drain();
    job(0, 200, 5, 0, EE ? 1 : 11, 0, 1'b1);
    drain();

    // back-to-back: i_valid held, operands change every cycle
    j = 0;
    i_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("b2b_ready", int'(o_ready),
          (i == 0 || i == 6 || i == 14) ? 1 : 0);
      if (o_ready && j < 3) begin
        i_a = 8'(ja[j]);
        i_b = 8'(jb[j]);
        i_n = N_W'(jn[j]);
        e.res = jr[j];
        e.cyc = cyc + jl[j];
        e.hold = 0;
        q.push_back(e);
        j++;
      end else begin
        i_a = 8'(i * 17 + 3);
        i_b = 8'(255 - i);
        i_n = N_W'(7);
      end
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    drain();
    chk("jobs_captured", j, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mult8_pow_seq.md
# mult8_pow_seq

Iterative sequencer that sits directly upstream of the registered 8×8 fractional multiplier (`mult8`) and drives its operand ports. It computes `a · bⁿ` by feeding one shared multiplier `n` times: the "rolled-up" form of an n-stage multiplier pipeline. The block accepts one job per valid/ready handshake and returns an 8-bit result through a second valid/ready handshake. The multiplier is instantiated beside it, not inside it.

## Interface
- `N_W`, default 3: width of the iteration count; maximum `n` is 2^N_W−1.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_arst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  job request.
- `o_ready`  out  1  block can accept a job; high only in IDLE.
- `i_a`  in  8  integer operand, with the binary point right of the LSB.
- `i_b`  in  8  fractional operand, with the binary point left of the MSB (0..255/256).
- `i_n`  in  N_W  number of multiplications to perform.
- `o_valid`  out  1  result available.
- `i_ready`  in  1  consumer accepts the result.
- `o_result`  out  8  `a · bⁿ`, truncated after each step.
- `o_mult_a`  out  8  to mult8 `i_a`; equals `acc_q`.
- `o_mult_b`  out  8  to mult8 `i_b`; equals `b_q`.
- `i_mult_product`  in  8  from mult8 `o_product`; registered, valid one cycle after the operands are presented.

## Operation
- Registers:
  - `acc_q[7:0]`
  - `b_q[7:0]`
  - `cnt_q[N_W-1:0]`
  - `state_q`, one of IDLE, ISSUE, WAIT, DONE.
- Reset values: state IDLE; `acc_q`, `b_q` and `cnt_q` are 0.
  - Therefore `o_ready`=1, `o_valid`=0, `o_result`=0, `o_mult_a`=0 and `o_mult_b`=0.
- IDLE:
  - On `i_valid && o_ready`, capture `acc_q←i_a`, `b_q←i_b`, `cnt_q←i_n`.
  - Next state is DONE if `i_n==0`, else ISSUE.
- ISSUE: the operands are already on `o_mult_a`/`o_mult_b`. Go to WAIT unconditionally.
- WAIT:
  - Capture `acc_q←i_mult_product` and `cnt_q←cnt_q−1`.
  - Next state is DONE if `cnt_q==1`, else ISSUE.
- DONE:
  - `o_valid`=1 and `o_result`=`acc_q`.
  - On `i_ready`, go to IDLE.
  - `o_result` stays stable while `o_valid && !i_ready`.
- Arithmetic per step: `acc = (acc·b)>>8`. `acc` is monotonically non-increasing, so no overflow is possible.
- `i_a`, `i_b` and `i_n` are sampled only on the input handshake. Changes at any other time are ignored.
- `i_valid` while not IDLE is ignored: `o_ready`=0 and no job is queued.
- `i_ready` outside DONE has no effect.
- `o_mult_a`/`o_mult_b` are meaningful only in ISSUE. They may toggle at other times, and the multiplier output is ignored except in WAIT.
- Reset asserted mid-job: all registers return to their reset values immediately, without waiting for a clock edge. The job is discarded and `o_valid` drops at once.

## Timing
- Cycle 0 is the cycle in which the input handshake is sampled at the closing edge.
- One multiplication takes 2 cycles (ISSUE then WAIT).
- `o_valid` first asserts in cycle 2n+1: cycle 1 for n=0, cycle 15 for n=7 with N_W=3.
- Result handshake completes in cycle k when `i_ready`=1 in cycle k. `o_ready` returns high in cycle k+1.
- Maximum throughput is one job per 2n+2 cycles.
- The `mult8` latency of exactly 1 register is required. Any other latency breaks the WAIT capture.

## Configuration
- `MULT8_POW_SEQ_EARLY_EXIT_EN` defined: the block finishes early once `acc` is zero.
  - WAIT transitions to DONE if `i_mult_product==0`, regardless of `cnt_q`.
  - IDLE transitions to DONE if `i_a==0`, regardless of `i_n`.
  - `o_result` is unchanged (0); only latency shrinks.
- Not defined: the count always runs to zero. Latency is exactly 2n+1 for every job.

## Test plan
- Reset, then idle: `o_ready`=1, `o_valid`=0, `o_result`=0 and `o_mult_a`/`o_mult_b`=0. Drop `i_arst_n` during WAIT: outputs return to those values with no clock edge.
- a=200, b=128, n=2 -> intermediate `acc`=100, then `o_result`=50 with `o_valid` rising in cycle 5. Hold `i_ready`=0 for 4 cycles: `o_result` stays 50 and `o_ready` stays 0.
- a=255, b=255, n=3 -> steps 254, 253, 252; `o_result`=252 in cycle 7. Also a=77, n=0 -> `o_result`=77 in cycle 1, with no ISSUE state entered.
- a=3, b=64, n=7 -> `o_result`=0.
  - With `MULT8_POW_SEQ_EARLY_EXIT_EN`: `o_valid` in cycle 3.
  - Without it: cycle 15.
  - a=0, n=5 with the macro: `o_valid` in cycle 1.
- Back-to-back jobs with `i_valid` held high and new operands presented every cycle:
  - Only the operands present in IDLE cycles are captured; second result is correct.
  - `o_ready` is low throughout the busy period.
  - `i_ready`=1 in the first DONE cycle gives `o_ready`=1 in the following cycle.
